uart_tx_buf: RTL
================

UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 Parameter CLOCK_FREQ_HZ, default 80000000, meaning: clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 230400, meaning: line bit rate.
REQ-003 Parameter FIFO_DEPTH, default 16, meaning: byte buffer entries, power of two, >= 2.
REQ-004 Parameter PARITY, default 0, meaning: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, default 1, meaning: stop bits per frame, 1 or 2.
REQ-006 Port clk  input  1  single clock; all logic on rising edge.
REQ-007 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 Port send  input  1  write strobe; one byte offered per high cycle.
REQ-009 Port tx_data  input  8  byte offered with send.
REQ-010 Port ready  output  1  high when FIFO not full; send accepted only when ready high.
REQ-011 Port overrun  output  1  one-cycle pulse when send high and ready low (byte dropped).
REQ-012 Port busy  output  1  high while FIFO non-empty or frame in progress.
REQ-013 Port level  output  clog2(FIFO_DEPTH+1)  bytes currently in FIFO (excludes byte in shift register).
REQ-014 Port tx  output  1  serial line, idle high, registered.

Function
REQ-015 CLKS_PER_BIT SHALL be CLOCK_FREQ_HZ/BAUD_RATE, integer truncation (347 at defaults); values < 2 SHALL be an elaboration error.
REQ-016 Every line bit SHALL last exactly CLKS_PER_BIT cycles; bit counter SHALL restart at each frame start, not free-run.
REQ-017 Frame SHALL be: start bit 0, 8 data bits LSB first, optional parity bit, STOP_BITS high bits.
REQ-018 Parity bit SHALL make total ones in data+parity even (PARITY=1) or odd (PARITY=2).
REQ-019 FSM states SHALL be IDLE, START, DATA, PAR, STOP; IDLE->START on FIFO non-empty; START->DATA; DATA->PAR after bit 7 if PARITY!=0 else ->STOP; PAR->STOP; STOP->START if FIFO non-empty at last stop-bit cycle, else ->IDLE.
REQ-020 FIFO pop SHALL occur on the IDLE->START or STOP->START transition edge; popped byte latched into shift register.
REQ-021 Latency: send accepted at edge E0 with FIFO empty and FSM IDLE -> tx low from edge E0+1.
REQ-022 Back-to-back bytes SHALL produce zero idle cycles between last stop bit and next start bit.
REQ-023 Push when ready low SHALL be discarded, FIFO unchanged, overrun pulsed one cycle.
REQ-024 Simultaneous push and pop SHALL leave level unchanged and accept the pushed byte.
REQ-025 ready SHALL equal (level != FIFO_DEPTH); level, ready, busy SHALL be updated same edge as push/pop.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; no byte reordering or duplication.
REQ-027 tx_data SHALL be ignored when send low.

Reset
REQ-028 rst_n low SHALL immediately force tx=1, ready=1, overrun=0, busy=0, level=0, FSM=IDLE, counters 0.
REQ-029 Reset mid-frame SHALL abort the frame and discard all FIFO contents; no partial frame resumes after release.
REQ-030 Reset release SHALL be synchronised so first possible push is the second edge after deassertion.

Structure
REQ-031 Shared package uart_pkg SHALL hold FSM state encodings, PARITY codes, and CLKS_PER_BIT/frame-length computation, shared with the receiver.
REQ-032 FIFO SHALL be one sub-module uart_tx_fifo (synchronous, registered count); FSM, bit timer and shifter stay in uart_tx_buf.

Verification (CLOCK_FREQ_HZ=1600, BAUD_RATE=100, so 16 clocks/bit)
REQ-033 Single send 0x55, PARITY=0 -> tx low 16 cycles from E0+1, then 1,0,1,0,1,0,1,0 at 16 cycles each, stop high 16; busy falls 160 cycles after E0+1.
REQ-034 18 consecutive sends 0x00..0x11, FIFO_DEPTH=16 -> first 17 accepted (0x00 popped at once), ready low after 17th, 0x11 dropped with one overrun pulse; line emits 0x00..0x10 in order.
REQ-035 PARITY=1, send 0x07 -> parity bit 1, frame 11 bits = 176 cycles; PARITY=2 same byte -> parity bit 0.
REQ-036 Send 0xA5, assert rst_n low during data bit 3 -> tx high, level 0, busy 0 in same cycle; after release tx stays high indefinitely.
REQ-037 Sends 0x31 then 0x32 on consecutive cycles -> second start bit begins cycle after first stop bit ends; total 320 busy cycles.
REQ-038 STOP_BITS=2, send 0xFF -> 32 high cycles after data before next start bit of a queued byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity codes and bit-timing helpers
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int DATA_BITS = 8;

  // Integer truncation is intentional: the bit period is a whole number of clocks.
  function automatic int clks_per_bit(input int clock_freq_hz, input int baud_rate);
    return clock_freq_hz / baud_rate;
  endfunction

  function automatic int frame_bits(input int parity, input int stop_bits);
    return 1 + DATA_BITS + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

  function automatic logic parity_of(input logic [7:0] data, input int parity);
    return (parity == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with a registered occupancy count; read data is the
// current head entry, valid whenever the FIFO is not empty.
module uart_tx_fifo #(
  parameter int DEPTH   = 16,
  parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [7:0]         wdata,
  input  logic               pop,
  output logic [7:0]         rdata,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] count;
  logic               wr_en;
  logic               rd_en;

  assign full  = (count == LEVEL_W'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign rdata = mem[rd_ptr];
  assign level = count;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + LEVEL_W'(1);
        2'b01:   count <= count - LEVEL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: byte FIFO feeding a frame FSM with a per-bit timer
// and an LSB-first shifter; the serial line output is registered.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = 80000000,
  parameter int BAUD_RATE     = 230400,
  parameter int FIFO_DEPTH    = 16,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             send,
  input  logic [7:0]                       tx_data,
  output logic                             ready,
  output logic                             overrun,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
  output logic                             tx
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int LEVEL_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_buf: CLOCK_FREQ_HZ/BAUD_RATE must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_buf: FIFO_DEPTH must be a power of two and at least 2");
  end
  if ((PARITY < PARITY_NONE) || (PARITY > PARITY_ODD)) begin : g_bad_parity
    $error("uart_tx_buf: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx_buf: STOP_BITS must be 1 or 2");
  end

  uart_state_t      state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic             stop_cnt;
  logic [7:0]       shifter;
  logic             par_bit;
  logic             rst_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_rdata;
  logic             push;
  logic             pop;
  logic             last_bit;
  logic             last_stop;

  // Reset is released one edge late so the first accepted push lands on the second edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_q <= 1'b0;
    end else begin
      rst_q <= 1'b1;
    end
  end

  assign ready     = ~fifo_full;
  assign push      = send & ready & rst_q;
  assign last_bit  = (bit_cnt == BIT_LAST);
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  assign pop       = ~fifo_empty & ((state == IDLE) | ((state == STOP) & last_bit & last_stop));
  assign busy      = (state != IDLE) | ~fifo_empty;

  uart_tx_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (tx_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shifter  <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      overrun  <= 1'b0;
    end else begin
      overrun <= send & ~ready & rst_q;
      case (state)
        IDLE: begin
          tx <= 1'b1;
        end
        START: begin
          if (last_bit) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= shifter[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (last_bit) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              if (PARITY != PARITY_NONE) begin
                state <= PAR;
                tx    <= par_bit;
              end else begin
                state    <= STOP;
                stop_cnt <= 1'b0;
                tx       <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shifter <= {1'b0, shifter[7:1]};
              tx      <= shifter[1];
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        PAR: begin
          if (last_bit) begin
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            state    <= STOP;
            tx       <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (last_bit) begin
            bit_cnt <= '0;
            if (last_stop) begin
              state <= IDLE;
              tx    <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
      // A pop always starts a fresh frame, overriding the transition chosen above.
      if (pop) begin
        state   <= START;
        bit_cnt <= '0;
        tx      <= 1'b0;
        shifter <= fifo_rdata;
        par_bit <= parity_of(fifo_rdata, PARITY);
      end
    end
  end

endmodule
